// File: rtl/gen_demux_8_1_wr_ctrl.sv
//------------------------------------------------------------------------------
// gen_demux_8_1_wr_ctrl
//
// Write-side controller for a two-bank ping-pong bit-plane buffer.
// Each accepted bit-sample is steered into one of 8 bit-planes through the
// 1:8 demux select CTRL_BIT_SEL_WR. After every eighth sample the word
// address advances. After WORDS words the matrix is complete, and the fill
// moves on to the other bank. The read side hands banks back with
// READ_ONE_MATRIX pulses.
//
// Ports
//   SYS_CLK          system clock, rising edge
//   SYS_RST          asynchronous, active-low reset
//   WR_EN            a bit-sample is presented this cycle
//   SOFT_CLR         restart the current matrix fill (bank state kept)
//   READ_ONE_MATRIX  one-cycle pulse: the read side consumed one bank
//   CTRL_BIT_SEL_WR  demux select (plane 0..7) for the current sample
//   WR_ADDR          write address {WR_BANK, word_addr}
//   WR_BANK          bank currently being filled
//   RD_BANK          bank the read side consumes next
//   WR_READY         a write is accepted this cycle
//   WR_ONE_MATRIX    combinational pulse on the last accepted write of a matrix
//   ONE_BANK_FULL    at least one bank holds a complete matrix
//   TWO_BANK_FULL    both banks hold complete matrices
//   OVERFLOW         sticky: a write was dropped
//   UNDERFLOW        sticky: a release arrived with no full bank
//------------------------------------------------------------------------------
module gen_demux_8_1_wr_ctrl #(
   parameter int WORDS  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              SYS_CLK,
   input  logic              SYS_RST,
   input  logic              WR_EN,
   input  logic              SOFT_CLR,
   input  logic              READ_ONE_MATRIX,
   output logic [2:0]        CTRL_BIT_SEL_WR,
   output logic [ADDR_W:0]   WR_ADDR,
   output logic              WR_BANK,
   output logic              RD_BANK,
   output logic              WR_READY,
   output logic              WR_ONE_MATRIX,
   output logic              ONE_BANK_FULL,
   output logic              TWO_BANK_FULL,
   output logic              OVERFLOW,
   output logic              UNDERFLOW
);

   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);
   localparam logic [1:0]        CNT_EMPTY = 2'd0;
   localparam logic [1:0]        CNT_TWO   = 2'd2;

   // Registered state
   logic [2:0]        bit_sel_reg,   bit_sel_next;
   logic [ADDR_W-1:0] word_addr_reg, word_addr_next;
   logic              wr_bank_reg,   wr_bank_next;
   logic              rd_bank_reg,   rd_bank_next;
   logic [1:0]        full_cnt_reg,  full_cnt_next;
   logic              one_full_reg,  two_full_reg;
   logic              overflow_reg,  overflow_next;
   logic              underflow_reg, underflow_next;

   // Per-cycle decodes
   logic ready;
   logic accept;
   logic slot_write;
   logic last_slot;
   logic complete;
   logic release_ok;

   // Readiness depends only on registered occupancy. A release in this
   // same cycle therefore cannot rescue a write that is presented while
   // both banks are full. WR_READY rises on the following cycle.
   assign ready      = (full_cnt_reg != CNT_TWO);
   assign accept     = WR_EN & ready;

   // SOFT_CLR wins over a same-cycle write. The sample is thrown away,
   // so it neither advances the slot nor completes a matrix.
   assign slot_write = accept & ~SOFT_CLR;
   assign last_slot  = (bit_sel_reg == 3'd7) & (word_addr_reg == LAST_WORD);
   assign complete   = slot_write & last_slot;
   assign release_ok = READ_ONE_MATRIX & (full_cnt_reg != CNT_EMPTY);

   always_comb begin
      bit_sel_next   = bit_sel_reg;
      word_addr_next = word_addr_reg;
      wr_bank_next   = wr_bank_reg;
      rd_bank_next   = rd_bank_reg;
      full_cnt_next  = full_cnt_reg;
      overflow_next  = overflow_reg;
      underflow_next = underflow_reg;

      // Slot sequencing: plane index is the fast counter, word is the slow one
      if (SOFT_CLR) begin
         bit_sel_next   = 3'd0;
         word_addr_next = '0;
      end else if (slot_write) begin
         bit_sel_next = bit_sel_reg + 3'd1;
         if (bit_sel_reg == 3'd7) begin
            // An explicit return to 0 is needed because WORDS may be
            // smaller than 2**ADDR_W.
            if (word_addr_reg == LAST_WORD) begin
               word_addr_next = '0;
               wr_bank_next   = ~wr_bank_reg;
            end else begin
               word_addr_next = word_addr_reg + 1'b1;
            end
         end
      end

      // Occupancy. A completion is only possible while full_cnt < 2 and
      // a release only while full_cnt > 0, so no explicit clamp is needed.
      if (complete && !release_ok) begin
         full_cnt_next = full_cnt_reg + 2'd1;
      end else if (release_ok && !complete) begin
         full_cnt_next = full_cnt_reg - 2'd1;
      end

      if (release_ok) begin
         rd_bank_next = ~rd_bank_reg;
      end

      // Sticky error flags
      if (WR_EN && !ready) begin
         overflow_next = 1'b1;
      end
      if (READ_ONE_MATRIX && (full_cnt_reg == CNT_EMPTY)) begin
         underflow_next = 1'b1;
      end
   end

   always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
      if (!SYS_RST) begin
         bit_sel_reg   <= 3'd0;
         word_addr_reg <= '0;
         wr_bank_reg   <= 1'b0;
         rd_bank_reg   <= 1'b0;
         full_cnt_reg  <= CNT_EMPTY;
         one_full_reg  <= 1'b0;
         two_full_reg  <= 1'b0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         bit_sel_reg   <= bit_sel_next;
         word_addr_reg <= word_addr_next;
         wr_bank_reg   <= wr_bank_next;
         rd_bank_reg   <= rd_bank_next;
         full_cnt_reg  <= full_cnt_next;
         // Flags are registered from the next count, so they always agree
         // with full_cnt_reg without adding a decode stage on the outputs.
         one_full_reg  <= (full_cnt_next != CNT_EMPTY);
         two_full_reg  <= (full_cnt_next == CNT_TWO);
         overflow_reg  <= overflow_next;
         underflow_reg <= underflow_next;
      end
   end

   assign CTRL_BIT_SEL_WR = bit_sel_reg;
   assign WR_ADDR         = {wr_bank_reg, word_addr_reg};
   assign WR_BANK         = wr_bank_reg;
   assign RD_BANK         = rd_bank_reg;
   assign WR_READY        = ready;
   assign WR_ONE_MATRIX   = complete;
   assign ONE_BANK_FULL   = one_full_reg;
   assign TWO_BANK_FULL   = two_full_reg;
   assign OVERFLOW        = overflow_reg;
   assign UNDERFLOW       = underflow_reg;

endmodule

// File: tb/tb_gen_demux_8_1_wr_ctrl.sv
//------------------------------------------------------------------------------
// tb_gen_demux_8_1_wr_ctrl
//
// Directed bench for gen_demux_8_1_wr_ctrl. A sample-index occupancy model
// gives the expected outputs, and these are compared on every falling edge.
// Literal checks at key points pin the model to hand-worked values.
//------------------------------------------------------------------------------
module tb_gen_demux_8_1_wr_ctrl;

   localparam int WORDS  = 4;
   localparam int ADDR_W = 2;
   localparam int SLOTS  = 8 * WORDS;

   logic              SYS_CLK = 1'b0;
   logic              SYS_RST = 1'b0;
   logic              WR_EN = 1'b0;
   logic              SOFT_CLR = 1'b0;
   logic              READ_ONE_MATRIX = 1'b0;
   logic [2:0]        CTRL_BIT_SEL_WR;
   logic [ADDR_W:0]   WR_ADDR;
   logic              WR_BANK;
   logic              RD_BANK;
   logic              WR_READY;
   logic              WR_ONE_MATRIX;
   logic              ONE_BANK_FULL;
   logic              TWO_BANK_FULL;
   logic              OVERFLOW;
   logic              UNDERFLOW;

   gen_demux_8_1_wr_ctrl #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
      .SYS_CLK(SYS_CLK), .SYS_RST(SYS_RST), .WR_EN(WR_EN), .SOFT_CLR(SOFT_CLR),
      .READ_ONE_MATRIX(READ_ONE_MATRIX), .CTRL_BIT_SEL_WR(CTRL_BIT_SEL_WR),
      .WR_ADDR(WR_ADDR), .WR_BANK(WR_BANK), .RD_BANK(RD_BANK),
      .WR_READY(WR_READY), .WR_ONE_MATRIX(WR_ONE_MATRIX),
      .ONE_BANK_FULL(ONE_BANK_FULL), .TWO_BANK_FULL(TWO_BANK_FULL),
      .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW));

   always #5 SYS_CLK = ~SYS_CLK;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   // Model: the position within the matrix is one sample index 0..SLOTS-1.
   // Occupancy is a plain integer count of complete banks.
   int m_idx, m_full;
   bit m_wbank, m_rbank, m_ovf, m_unf;

   always @(posedge SYS_CLK or negedge SYS_RST) begin
      if (!SYS_RST) begin
         m_idx <= 0; m_full <= 0; m_wbank <= 0; m_rbank <= 0;
         m_ovf <= 0; m_unf <= 0;
      end else begin
         int  nidx, nfull;
         bit  ok, done, rel;
         ok    = WR_EN && (m_full != 2);
         done  = 0;
         nidx  = m_idx;
         if (SOFT_CLR) nidx = 0;
         else if (ok) begin
            if (m_idx == SLOTS - 1) begin nidx = 0; done = 1; end
            else nidx = m_idx + 1;
         end
         rel   = READ_ONE_MATRIX && (m_full != 0);
         nfull = m_full + (done ? 1 : 0) - (rel ? 1 : 0);
         m_idx  <= nidx;
         m_full <= nfull;
         if (done) m_wbank <= ~m_wbank;
         if (rel)  m_rbank <= ~m_rbank;
         if (WR_EN && m_full == 2) m_ovf <= 1;
         if (READ_ONE_MATRIX && m_full == 0) m_unf <= 1;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge SYS_CLK) begin
      if (chk_en) begin
         chk("sel",   int'(CTRL_BIT_SEL_WR), m_idx % 8);
         chk("addr",  int'(WR_ADDR), int'(m_wbank) * (1 << ADDR_W) + m_idx / 8);
         chk("wbank", int'(WR_BANK), int'(m_wbank));
         chk("rbank", int'(RD_BANK), int'(m_rbank));
         chk("ready", int'(WR_READY), (m_full != 2) ? 1 : 0);
         chk("wom",   int'(WR_ONE_MATRIX),
             (WR_EN && m_full != 2 && !SOFT_CLR && m_idx == SLOTS - 1) ? 1 : 0);
         chk("one",   int'(ONE_BANK_FULL), (m_full >= 1) ? 1 : 0);
         chk("two",   int'(TWO_BANK_FULL), (m_full == 2) ? 1 : 0);
         chk("ovf",   int'(OVERFLOW), int'(m_ovf));
         chk("unf",   int'(UNDERFLOW), int'(m_unf));
      end
   end

   // Drive inputs just after an edge and hold them until the next edge
   task automatic apply(input logic we, input logic clr, input logic rd);
      WR_EN = we; SOFT_CLR = clr; READ_ONE_MATRIX = rd;
      #1;
   endtask

   task automatic step();
      @(posedge SYS_CLK); #1;
      WR_EN = 0; SOFT_CLR = 0; READ_ONE_MATRIX = 0;
   endtask

   task automatic writes(input int n);
      for (int i = 0; i < n; i++) begin apply(1, 0, 0); step(); end
   endtask

   task automatic do_reset();
      SYS_RST = 0;
      repeat (2) @(posedge SYS_CLK);
      #1 SYS_RST = 1;
   endtask

   initial begin
      do_reset();
      chk_en = 1;
      // Reset state
      chk("rst_ready", int'(WR_READY), 1);
      chk("rst_addr",  int'(WR_ADDR), 0);
      chk("rst_one",   int'(ONE_BANK_FULL), 0);

      // 1: one full matrix, WR_ONE_MATRIX only on write 32
      writes(31);
      apply(1, 0, 0);
      chk("t1_wom31", int'(WR_ONE_MATRIX), 1);
      chk("t1_sel31", int'(CTRL_BIT_SEL_WR), 7);
      chk("t1_addr31", int'(WR_ADDR), 3);
      step();
      chk("t1_addr", int'(WR_ADDR), 4);
      chk("t1_wbank", int'(WR_BANK), 1);
      chk("t1_one", int'(ONE_BANK_FULL), 1);
      chk("t1_two", int'(TWO_BANK_FULL), 0);

      // 2: second matrix fills both banks; write 65 is dropped
      writes(32);
      chk("t2_two", int'(TWO_BANK_FULL), 1);
      chk("t2_ready", int'(WR_READY), 0);
      apply(1, 0, 0);
      step();
      chk("t2_ovf", int'(OVERFLOW), 1);
      chk("t2_addr", int'(WR_ADDR), 0);
      chk("t2_sel", int'(CTRL_BIT_SEL_WR), 0);

      // 3: release together with a write that must still be dropped
      apply(1, 0, 1);
      chk("t3_wom_drop", int'(WR_ONE_MATRIX), 0);
      step();
      chk("t3_rbank", int'(RD_BANK), 1);
      chk("t3_ready", int'(WR_READY), 1);
      chk("t3_two", int'(TWO_BANK_FULL), 0);
      chk("t3_sel", int'(CTRL_BIT_SEL_WR), 0);
      chk("t3_addr", int'(WR_ADDR), 0);
      writes(1);
      chk("t3_sel1", int'(CTRL_BIT_SEL_WR), 1);

      // 4: completion and release in the same cycle
      writes(30);
      apply(1, 0, 1);
      chk("t4_wom", int'(WR_ONE_MATRIX), 1);
      step();
      chk("t4_one", int'(ONE_BANK_FULL), 1);
      chk("t4_two", int'(TWO_BANK_FULL), 0);
      chk("t4_wbank", int'(WR_BANK), 1);
      chk("t4_rbank", int'(RD_BANK), 0);

      // 5: release immediately after reset
      do_reset();
      apply(0, 0, 1);
      step();
      chk("t5_unf", int'(UNDERFLOW), 1);
      chk("t5_one", int'(ONE_BANK_FULL), 0);
      chk("t5_rbank", int'(RD_BANK), 0);
      chk("t5_ovf", int'(OVERFLOW), 0);

      // 6: SOFT_CLR with a write after 13 samples
      writes(13);
      chk("t6_sel13", int'(CTRL_BIT_SEL_WR), 5);
      chk("t6_addr13", int'(WR_ADDR), 1);
      apply(1, 1, 0);
      chk("t6_wom", int'(WR_ONE_MATRIX), 0);
      step();
      chk("t6_sel", int'(CTRL_BIT_SEL_WR), 0);
      chk("t6_addr", int'(WR_ADDR), 0);
      chk("t6_unf", int'(UNDERFLOW), 1);
      writes(31);
      chk("t6_one31", int'(ONE_BANK_FULL), 0);
      // SOFT_CLR on what would be the final slot: no completion
      apply(1, 1, 0);
      chk("t6_wom_clr", int'(WR_ONE_MATRIX), 0);
      step();
      chk("t6_one_clr", int'(ONE_BANK_FULL), 0);
      writes(32);
      chk("t6_one", int'(ONE_BANK_FULL), 1);
      chk("t6_wbank", int'(WR_BANK), 1);

      // A release must still be applied when SOFT_CLR is high in the same cycle
      apply(0, 1, 1);
      step();
      chk("t6_clr_rel_one", int'(ONE_BANK_FULL), 0);
      chk("t6_clr_rel_rbank", int'(RD_BANK), 1);

      // Asynchronous reset mid-matrix discards the partial fill
      writes(5);
      #2 SYS_RST = 0;
      #1;
      chk("arst_sel", int'(CTRL_BIT_SEL_WR), 0);
      chk("arst_wbank", int'(WR_BANK), 0);
      chk("arst_unf", int'(UNDERFLOW), 0);
      @(posedge SYS_CLK); #1 SYS_RST = 1;
      writes(3);

      chk_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
